led_bist_checker: RTL and testbench
===================================

# led_bist_checker

Response analyzer for the switch/LED built-in self-test. It observes the 4-bit LED drive and the switch inputs. In pattern mode it locks onto the walking-ones LED sequence and checks every step. In manual mode it checks that the LEDs mirror the switches. It counts errors and completed pattern cycles, and sits beside the LED generator in the board top level with its status routed to debug LEDs or an ILA.

## Interface
- `TIMEOUT`, default 64: clocks without an LED change in TRACK before a stall error is declared. Must exceed twice the pattern step period.
- `SETTLE`, default 4: clocks a switch value must be stable before the LED is compared against it (1..255).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `led_in`  in  4  observed LED drive.
- `sw`  in  4  switch inputs.
- `state`  out  2  00 HUNT, 01 TRACK, 10 MANUAL.
- `locked`  out  1  high while in TRACK.
- `cycle_done`  out  1  one-clock pulse when a full pattern cycle has been verified.
- `cycles_ok`  out  8  verified pattern cycles; saturates at 255.
- `err_count`  out  8  detected errors; saturates at 255.
- `fail`  out  1  sticky; set on the first error and cleared only by `rst`.

## Operation
- Input stage:
  - `led_q <= led_in`, `led_p <= led_q`, `sw_q <= sw`.
  - `chg` = (`led_q != led_p`).
- Expected sequence of distinct values (the repeated 0000 collapses to one step), idx 0..7: 1000, 1100, 1110, 1111, 1110, 1100, 1000, 0000.
- MANUAL has the highest priority. `sw_q != 0` forces MANUAL from any state in the same clock. No pattern compare is made in that clock.
- HUNT:
  - On `chg` with `led_p == 0000` and `led_q == 1000`: go to TRACK, set `idx <= 1`, clear the watchdog.
  - All other changes are ignored. No errors are raised in HUNT.
- TRACK:
  - Watchdog increments every clock and clears on `chg`.
  - On `chg` with `led_q == exp[idx]`: `idx <= (idx+1) mod 8`.
    - If the accepted step was idx 7: `cycles_ok` +1 (saturating) and `cycle_done` pulses.
  - On `chg` with a mismatch: `err_count` +1 (saturating), `fail <= 1`, go to HUNT.
  - Watchdog reaching `TIMEOUT` with no `chg`: `err_count` +1, `fail <= 1`, go to HUNT.
  - A mismatch and a timeout in the same clock is impossible, because `chg` clears the watchdog. If it ever occurs, count one error.
- MANUAL:
  - The settle counter clears whenever `sw_q` changes and otherwise counts up, saturating at `SETTLE`.
  - On the clock where the counter first equals `SETTLE`: compare `led_q` with `sw_q`. A mismatch gives `err_count` +1 and `fail <= 1`.
  - Exactly one compare is made per stable switch value.
  - `sw_q == 0` returns to HUNT, clearing idx, the watchdog and the settle counter.
- Counters never wrap; both hold at 255.

## Timing
- Reset values: `state` = 00, `locked` = 0, `cycle_done` = 0, `cycles_ok` = 0, `err_count` = 0, `fail` = 0. Internal flops are cleared, including `led_q`, `led_p`, `sw_q`, idx, the watchdog and the settle counter.
- Asserting `rst` mid-operation aborts any state and restores all reset values on the next edge.
- An LED change at the `led_in` pins is reflected in the registered outputs 3 clocks later: `led_q`, then `chg`, then the output register.
- A switch change reaches MANUAL 2 clocks later.
- The MANUAL compare result appears 2 + `SETTLE` + 1 clocks after a switch change.
- Stall error: `err_count` increments `TIMEOUT` clocks after the last registered change.
- All outputs are registered. `cycle_done` is high for exactly one clock.

## Test plan
- Reset: hold `rst` 3 clocks with random inputs → all outputs 0 and `state` = 00. Release with `led_in` = 0000 → the block stays in HUNT.
- Clean pattern: step `led_in` every 8 clocks through 0000, then 1000, 1100, 1110, 1111, 1110, 1100, 1000, 0000, 0000, repeated 3 times.
  - `locked` rises 3 clocks after the first 1000.
  - `cycle_done` pulses 3 times; `cycles_ok` = 3.
  - `err_count` = 0 and `fail` = 0.
- Corruption: during TRACK, drive 1010 where 1110 is expected → `err_count` = 1, `fail` = 1, `state` = HUNT. The block relocks on the next 0000→1000, and `fail` stays 1.
- Stall: in TRACK, hold 1100 for 100 clocks (`TIMEOUT` = 64) → exactly one error, raised 64 clocks after the change was registered, followed by a return to HUNT.
- Manual mode:
  - `sw` = 0101 with `led_in` = 0101 → `state` = 10, no error.
  - Then `sw` = 0011 with `led_in` held at 0101 → `err_count` +1 exactly once, `SETTLE` + 3 clocks after the switch change.
  - `sw` = 0000 → `state` = 00.
- Saturation: inject 300 mismatches by toggling between HUNT relock and a wrong step → `err_count` holds at 255 and `fail` = 1.

Source files
------------

// File: rtl/led_bist_checker.sv
// Response analyzer for the switch/LED self-test: follows the walking-ones LED
// pattern, checks manual switch mirroring, and counts errors and verified cycles.
module led_bist_checker #(
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] led_in,
    input  logic [3:0] sw,
    output logic [1:0] state,
    output logic       locked,
    output logic       cycle_done,
    output logic [7:0] cycles_ok,
    output logic [7:0] err_count,
    output logic       fail
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_HUNT   = 2'b00,
        S_TRACK  = 2'b01,
        S_MANUAL = 2'b10
    } state_t;

    state_t     r_state;
    logic [3:0] r_ledQ;
    logic [3:0] r_ledP;
    logic       r_chg;
    logic [3:0] r_chgNew;
    logic [3:0] r_chgOld;
    logic [3:0] r_swQ;
    logic [3:0] r_swP;
    logic [2:0] r_idx;
    logic [WD_W-1:0] r_wd;
    logic [7:0] r_settle;
    logic       r_cmpDone;

    logic w_manualReq;
    logic w_swChg;
    logic w_expMatch;
    logic w_lockEvt;
    logic w_stepOk;
    logic w_trackBad;
    logic w_manualBad;
    logic w_errEvt;
    logic w_cycleEvt;

    // Distinct LED values of one walking-ones cycle; the doubled 0000 is one step.
    function automatic logic [3:0] expAt(input logic [2:0] i);
        case (i)
            3'd0:    expAt = 4'b1000;
            3'd1:    expAt = 4'b1100;
            3'd2:    expAt = 4'b1110;
            3'd3:    expAt = 4'b1111;
            3'd4:    expAt = 4'b1110;
            3'd5:    expAt = 4'b1100;
            3'd6:    expAt = 4'b1000;
            default: expAt = 4'b0000;
        endcase
    endfunction

    // The change flag is registered together with the before/after values it
    // describes, so the FSM always judges a change against its own context.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ledQ   <= '0;
            r_ledP   <= '0;
            r_chg    <= 1'b0;
            r_chgNew <= '0;
            r_chgOld <= '0;
            r_swQ    <= '0;
            r_swP    <= '0;
        end else begin
            r_ledQ   <= led_in;
            r_ledP   <= r_ledQ;
            r_chg    <= (r_ledQ != r_ledP);
            r_chgNew <= r_ledQ;
            r_chgOld <= r_ledP;
            r_swQ    <= sw;
            r_swP    <= r_swQ;
        end
    end

    always_comb begin
        w_manualReq = (r_swQ != 4'b0000);
        w_swChg     = (r_swQ != r_swP);
        w_expMatch  = (r_chgNew == expAt(r_idx));
        w_lockEvt   = (r_state == S_HUNT) && !w_manualReq && r_chg &&
                      (r_chgOld == 4'b0000) && (r_chgNew == 4'b1000);
        w_stepOk    = (r_state == S_TRACK) && !w_manualReq && r_chg && w_expMatch;
        w_trackBad  = (r_state == S_TRACK) && !w_manualReq &&
                      ((r_chg && !w_expMatch) ||
                       (!r_chg && (r_wd == WD_W'(TIMEOUT - 1))));
        w_manualBad = (r_state == S_MANUAL) && w_manualReq && !w_swChg &&
                      (r_settle == 8'(SETTLE)) && !r_cmpDone &&
                      (r_ledQ != r_swQ);
        w_errEvt    = w_trackBad || w_manualBad;
        w_cycleEvt  = w_stepOk && (r_idx == 3'd7);
    end

    // Mode FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_HUNT;
            r_idx      <= '0;
            r_wd       <= '0;
            r_settle   <= '0;
            r_cmpDone  <= 1'b0;
            locked     <= 1'b0;
            cycle_done <= 1'b0;
            cycles_ok  <= '0;
            err_count  <= '0;
            fail       <= 1'b0;
        end else begin
            cycle_done <= w_cycleEvt;
            if (w_errEvt) begin
                fail <= 1'b1;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
            if (w_cycleEvt && (cycles_ok != 8'hFF)) begin
                cycles_ok <= cycles_ok + 8'd1;
            end

            if (w_manualReq) begin
                r_state <= S_MANUAL;
                locked  <= 1'b0;
                if (w_swChg) begin
                    r_settle  <= '0;
                    r_cmpDone <= 1'b0;
                end else begin
                    if (r_settle != 8'(SETTLE)) begin
                        r_settle <= r_settle + 8'd1;
                    end else begin
                        r_cmpDone <= 1'b1;
                    end
                end
            end else begin
                case (r_state)
                    S_HUNT: begin
                        if (w_lockEvt) begin
                            r_state <= S_TRACK;
                            locked  <= 1'b1;
                            r_idx   <= 3'd1;
                            r_wd    <= '0;
                        end
                    end
                    S_TRACK: begin
                        if (w_trackBad) begin
                            r_state <= S_HUNT;
                            locked  <= 1'b0;
                            r_idx   <= '0;
                            r_wd    <= '0;
                        end else if (r_chg) begin
                            r_wd  <= '0;
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= S_HUNT;
                        locked    <= 1'b0;
                        r_idx     <= '0;
                        r_wd      <= '0;
                        r_settle  <= '0;
                        r_cmpDone <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_led_bist_checker.sv
// Directed bench for led_bist_checker: reset, clean pattern, corruption, stall,
// manual mirroring, error saturation and mid-run reset.
module tb_led_bist_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] led_in;
    logic [3:0] sw;
    logic [1:0] state;
    logic       locked;
    logic       cycle_done;
    logic [7:0] cycles_ok;
    logic [7:0] err_count;
    logic       fail;

    int total = 0;
    int bad   = 0;
    int pulseCount = 0;

    led_bist_checker #(.TIMEOUT(64), .SETTLE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .sw         (sw),
        .state      (state),
        .locked     (locked),
        .cycle_done (cycle_done),
        .cycles_ok  (cycles_ok),
        .err_count  (err_count),
        .fail       (fail)
    );

    always #5 clk = ~clk;

    // Each negedge with cycle_done high counts as one clock of pulse.
    always @(negedge clk) begin
        if (cycle_done) pulseCount++;
    end

    task automatic applyStimulus(input logic [3:0] led, input logic [3:0] s);
        led_in = led;
        sw     = s;
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0] pattern [10];

    initial begin
        pattern[0] = 4'b0000; pattern[1] = 4'b1000; pattern[2] = 4'b1100;
        pattern[3] = 4'b1110; pattern[4] = 4'b1111; pattern[5] = 4'b1110;
        pattern[6] = 4'b1100; pattern[7] = 4'b1000; pattern[8] = 4'b0000;
        pattern[9] = 4'b0000;

        // Reset with random inputs.
        rst = 1'b1;
        applyStimulus(4'($urandom), 4'($urandom));
        @(negedge clk);
        applyStimulus(4'($urandom), 4'($urandom));
        waitClocks(3);
        checkOutput("rst_state", {6'd0, state}, 8'd0);
        checkOutput("rst_locked", {7'd0, locked}, 8'd0);
        checkOutput("rst_cycle_done", {7'd0, cycle_done}, 8'd0);
        checkOutput("rst_cycles_ok", cycles_ok, 8'd0);
        checkOutput("rst_err", err_count, 8'd0);
        checkOutput("rst_fail", {7'd0, fail}, 8'd0);
        applyStimulus(4'b0000, 4'b0000);
        rst = 1'b0;
        waitClocks(10);
        checkOutput("idle_state", {6'd0, state}, 8'd0);
        checkOutput("idle_err", err_count, 8'd0);

        // Clean pattern, three full cycles.
        pulseCount = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) begin
                applyStimulus(pattern[i], 4'b0000);
                if (r == 0 && i == 1) begin
                    waitClocks(2);
                    checkOutput("lock_early", {7'd0, locked}, 8'd0);
                    waitClocks(1);
                    checkOutput("lock_at3", {7'd0, locked}, 8'd1);
                    waitClocks(5);
                end else begin
                    waitClocks(8);
                end
            end
        end
        checkOutput("clean_pulses", 8'(pulseCount), 8'd3);
        checkOutput("clean_cycles_ok", cycles_ok, 8'd3);
        checkOutput("clean_err", err_count, 8'd0);
        checkOutput("clean_fail", {7'd0, fail}, 8'd0);
        checkOutput("clean_state", {6'd0, state}, 8'd1);

        // Corruption: 1010 where 1110 is expected.
        applyStimulus(4'b1000, 4'b0000); waitClocks(8);
        applyStimulus(4'b1100, 4'b0000); waitClocks(8);
        applyStimulus(4'b1010, 4'b0000); waitClocks(3);
        checkOutput("corr_err", err_count, 8'd1);
        checkOutput("corr_fail", {7'd0, fail}, 8'd1);
        checkOutput("corr_state", {6'd0, state}, 8'd0);
        applyStimulus(4'b0000, 4'b0000); waitClocks(8);
        applyStimulus(4'b1000, 4'b0000); waitClocks(8);
        checkOutput("relock_state", {6'd0, state}, 8'd1);
        checkOutput("relock_fail", {7'd0, fail}, 8'd1);
        checkOutput("relock_err", err_count, 8'd1);

        // Stall: hold 1100; error lands 64 clocks after the change is registered.
        applyStimulus(4'b1100, 4'b0000);
        waitClocks(66);
        checkOutput("stall_before", err_count, 8'd1);
        checkOutput("stall_still_track", {6'd0, state}, 8'd1);
        waitClocks(1);
        checkOutput("stall_err", err_count, 8'd2);
        checkOutput("stall_state", {6'd0, state}, 8'd0);
        waitClocks(33);
        checkOutput("stall_once", err_count, 8'd2);

        // Manual mode.
        applyStimulus(4'b0101, 4'b0101);
        waitClocks(1);
        checkOutput("man_not_yet", {6'd0, state}, 8'd0);
        waitClocks(1);
        checkOutput("man_state", {6'd0, state}, 8'd2);
        checkOutput("man_locked", {7'd0, locked}, 8'd0);
        waitClocks(10);
        checkOutput("man_match_err", err_count, 8'd2);
        applyStimulus(4'b0101, 4'b0011);
        waitClocks(6);
        checkOutput("man_mis_before", err_count, 8'd2);
        waitClocks(1);
        checkOutput("man_mis_err", err_count, 8'd3);
        waitClocks(10);
        checkOutput("man_mis_once", err_count, 8'd3);
        applyStimulus(4'b0101, 4'b0000);
        waitClocks(2);
        checkOutput("man_exit_state", {6'd0, state}, 8'd0);

        // Saturation: 300 lock-then-mismatch rounds.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(4'b0000, 4'b0000); waitClocks(4);
            applyStimulus(4'b1000, 4'b0000); waitClocks(4);
            applyStimulus(4'b0101, 4'b0000); waitClocks(4);
            if (k == 10) checkOutput("sat_progress", err_count, 8'd14);
        end
        checkOutput("sat_err", err_count, 8'd255);
        checkOutput("sat_fail", {7'd0, fail}, 8'd1);
        checkOutput("sat_state", {6'd0, state}, 8'd0);

        // Mid-run reset from TRACK.
        applyStimulus(4'b0000, 4'b0000); waitClocks(4);
        applyStimulus(4'b1000, 4'b0000); waitClocks(4);
        checkOutput("pre_rst_state", {6'd0, state}, 8'd1);
        rst = 1'b1;
        waitClocks(1);
        checkOutput("mid_rst_state", {6'd0, state}, 8'd0);
        checkOutput("mid_rst_locked", {7'd0, locked}, 8'd0);
        checkOutput("mid_rst_err", err_count, 8'd0);
        checkOutput("mid_rst_fail", {7'd0, fail}, 8'd0);
        checkOutput("mid_rst_cycles", cycles_ok, 8'd0);
        rst = 1'b0;
        waitClocks(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
